// File: rtl/add_arbiter.sv
// add_arbiter: two-requester round-robin arbiter feeding a multi-cycle 8-bit adder.
// Optional signed-overflow output is enabled by defining ADD_ARBITER_OVF_EN.
module add_arbiter #(
    parameter int ADD_CYCLES = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_valid_i,
    output logic [1:0] req_ready_o,
    input  logic [7:0] req0_a_i,
    input  logic [7:0] req0_b_i,
    input  logic [7:0] req1_a_i,
    input  logic [7:0] req1_b_i,
    input  logic [1:0] req_cin_i,
    output logic       rsp_valid_o,
    input  logic       rsp_ready_i,
    output logic       rsp_id_o,
    output logic [7:0] rsp_sum_o,
`ifdef ADD_ARBITER_OVF_EN
    output logic       rsp_ovf_o,
`endif
    output logic       rsp_cout_o
);

    typedef enum logic [1:0] {IDLE, ADD, RESP} state_e;

    localparam logic [1:0] LAST = 2'(ADD_CYCLES - 1);

    state_e     state_q;
    logic       prio_q;
    logic [1:0] cnt_q;
    logic [7:0] a_q, b_q;
    logic       cin_q, id_q;
    logic       gnt_idx, hs;
    logic [8:0] sum_d;

    // Grant is combinational so the requester sees ready in the same cycle it asks;
    // ready is forced low while reset is held.
    always_comb begin
        gnt_idx     = (&req_valid_i) ? prio_q : req_valid_i[1];
        req_ready_o = (rst_ni && state_q == IDLE && |req_valid_i) ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
        hs          = |req_ready_o;
        sum_d       = {1'b0, a_q} + {1'b0, b_q} + {8'b0, cin_q};
    end

    // Control FSM: latch operands on grant, count ADD cycles, hold result until consumed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            cnt_q       <= 2'd0;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            cin_q       <= 1'b0;
            id_q        <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_id_o    <= 1'b0;
            rsp_sum_o   <= 8'h00;
            rsp_cout_o  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (hs) begin
                    a_q     <= gnt_idx ? req1_a_i : req0_a_i;
                    b_q     <= gnt_idx ? req1_b_i : req0_b_i;
                    cin_q   <= req_cin_i[gnt_idx];
                    id_q    <= gnt_idx;
                    prio_q  <= ~gnt_idx;
                    cnt_q   <= 2'd0;
                    state_q <= ADD;
                end
                ADD: if (cnt_q == LAST) begin
                    cnt_q                   <= 2'd0;
                    {rsp_cout_o, rsp_sum_o} <= sum_d;
                    rsp_id_o                <= id_q;
                    rsp_valid_o             <= 1'b1;
                    state_q                 <= RESP;
                end else begin
                    cnt_q <= cnt_q + 2'd1;
                end
                RESP: if (rsp_ready_i) begin
                    rsp_valid_o <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ADD_ARBITER_OVF_EN
    // Signed overflow captured alongside the sum: operands agree in sign, result does not.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rsp_ovf_o <= 1'b0;
        else if (state_q == ADD && cnt_q == LAST) rsp_ovf_o <= (a_q[7] == b_q[7]) & (sum_d[7] != a_q[7]);
    end
`endif

endmodule

// File: tb/tb_add_arbiter.sv
// tb_add_arbiter: directed self-checking bench for add_arbiter at ADD_CYCLES = 1, 3 and 4.
module tb_add_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [7:0] a0, b0, a1, b1;
    logic [1:0] cin;
    logic       rsp_ready;
    int         n_checks = 0;
    int         n_fail = 0;

    logic [1:0] rdy1, rdy3, rdy4;
    logic       vld1, vld3, vld4, id1, id3, id4, co1, co3, co4;
    logic [7:0] sum1, sum3, sum4;
`ifdef ADD_ARBITER_OVF_EN
    logic       ovf1, ovf3, ovf4;
`endif

    always #5 clk = ~clk;

    add_arbiter #(.ADD_CYCLES(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy1),
        .req0_a_i(a0), .req0_b_i(b0), .req1_a_i(a1), .req1_b_i(b1), .req_cin_i(cin),
        .rsp_valid_o(vld1), .rsp_ready_i(rsp_ready), .rsp_id_o(id1), .rsp_sum_o(sum1),
`ifdef ADD_ARBITER_OVF_EN
        .rsp_ovf_o(ovf1),
`endif
        .rsp_cout_o(co1)
    );

    add_arbiter #(.ADD_CYCLES(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy3),
        .req0_a_i(a0), .req0_b_i(b0), .req1_a_i(a1), .req1_b_i(b1), .req_cin_i(cin),
        .rsp_valid_o(vld3), .rsp_ready_i(rsp_ready), .rsp_id_o(id3), .rsp_sum_o(sum3),
`ifdef ADD_ARBITER_OVF_EN
        .rsp_ovf_o(ovf3),
`endif
        .rsp_cout_o(co3)
    );

    add_arbiter #(.ADD_CYCLES(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy4),
        .req0_a_i(a0), .req0_b_i(b0), .req1_a_i(a1), .req1_b_i(b1), .req_cin_i(cin),
        .rsp_valid_o(vld4), .rsp_ready_i(rsp_ready), .rsp_id_o(id4), .rsp_sum_o(sum4),
`ifdef ADD_ARBITER_OVF_EN
        .rsp_ovf_o(ovf4),
`endif
        .rsp_cout_o(co4)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        req_valid = 2'b00;
        {a0, b0, a1, b1} = '0;
        cin = 2'b00;
        rsp_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 1'b0;
        #2;
        n_checks++;
        if (rdy1 !== 2'b00 || rdy4 !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ready: got %b/%b exp 00", rdy1, rdy4);
        end
        n_checks++;
        if ({vld1, id1, sum1, co1} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got vld=%b id=%b sum=%h cout=%b exp all zero", vld1, id1, sum1, co1);
        end
        do_reset();
    endtask

    task automatic test_single;
        do_reset();
        req_valid = 2'b01; a0 = 8'h7F; b0 = 8'h00; cin = 2'b01;
        #1;
        n_checks++;
        if (rdy1 !== 2'b01) begin
            n_fail++;
            $display("FAIL single_ready: got %b exp 01", rdy1);
        end
        tick();
        req_valid = 2'b00;
        n_checks++;
        if (vld1 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early_valid: got %b exp 0", vld1);
        end
        tick();
        n_checks++;
        if ({vld1, sum1, co1, id1} !== {1'b1, 8'h80, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL single_rsp: got vld=%b sum=%h cout=%b id=%b exp 1 80 0 0", vld1, sum1, co1, id1);
        end
`ifdef ADD_ARBITER_OVF_EN
        n_checks++;
        if (ovf1 !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ovf: got %b exp 1", ovf1);
        end
`endif
        rsp_ready = 1'b1;
        tick();
        n_checks++;
        if (vld1 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drop: got %b exp 0", vld1);
        end
        req_valid = 2'b01; a0 = 8'hFF; b0 = 8'h01; cin = 2'b00;
        tick();
        req_valid = 2'b00;
        tick();
        n_checks++;
        if ({vld1, sum1, co1} !== {1'b1, 8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL wrap_rsp: got vld=%b sum=%h cout=%b exp 1 00 1", vld1, sum1, co1);
        end
        tick();
        n_checks++;
        if (vld1 !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_drop: got %b exp 0", vld1);
        end
    endtask

    task automatic test_contention;
        int k = 0;
        rst_n = 1'b0;
        req_valid = 2'b11;
        a0 = 8'h0E; b0 = 8'h03; a1 = 8'hFE; b1 = 8'h05; cin = 2'b00;
        rsp_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 40 && k < 4; c++) begin
            tick();
            if (vld1) begin
                n_checks++;
                if (id1 !== k[0] || sum1 !== (k[0] ? 8'h03 : 8'h11) || co1 !== k[0] || rdy1 !== 2'b00) begin
                    n_fail++;
                    $display("FAIL contention_rsp%0d: got id=%b sum=%h cout=%b rdy=%b exp id=%b sum=%h cout=%b rdy=00",
                             k, id1, sum1, co1, rdy1, k[0], k[0] ? 8'h03 : 8'h11, k[0]);
                end
                k++;
            end
        end
        n_checks++;
        if (k != 4) begin
            n_fail++;
            $display("FAIL contention_count: got %0d responses exp 4", k);
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        req_valid = 2'b01; a0 = 8'h10; b0 = 8'h20; a1 = 8'h33; b1 = 8'h44; cin = 2'b00;
        tick();
        req_valid = 2'b10;
        tick();
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if ({vld1, sum1, id1, rdy1} !== {1'b1, 8'h30, 1'b0, 2'b00}) begin
                n_fail++;
                $display("FAIL backpressure_hold%0d: got vld=%b sum=%h id=%b rdy=%b exp 1 30 0 00", i, vld1, sum1, id1, rdy1);
            end
            if (i < 5) tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_checks++;
        if (vld1 !== 1'b0 || rdy1 !== 2'b10) begin
            n_fail++;
            $display("FAIL backpressure_regrant: got vld=%b rdy=%b exp 0 10", vld1, rdy1);
        end
        tick();
        req_valid = 2'b00;
        tick();
        n_checks++;
        if ({vld1, id1, sum1, co1} !== {1'b1, 1'b1, 8'h77, 1'b0}) begin
            n_fail++;
            $display("FAIL backpressure_req1: got vld=%b id=%b sum=%h cout=%b exp 1 1 77 0", vld1, id1, sum1, co1);
        end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        do_reset();
        rsp_ready = 1'b1;
        req_valid = 2'b01; a0 = 8'h01; b0 = 8'h02;
        tick();
        req_valid = 2'b00;
        while (!vld3 && n < 10) begin
            tick();
            n++;
        end
        n_checks++;
        if (vld3 !== 1'b1 || sum3 !== 8'h03) begin
            n_fail++;
            $display("FAIL midreset_prime: got vld=%b sum=%h exp 1 03", vld3, sum3);
        end
        tick();
        req_valid = 2'b01; a0 = 8'h10; b0 = 8'h10;
        tick();
        req_valid = 2'b00;
        tick();
        #1 rst_n = 1'b0;
        req_valid = 2'b01;
        #1;
        n_checks++;
        if ({vld3, id3, sum3, co3, rdy3} !== 13'd0) begin
            n_fail++;
            $display("FAIL midreset_async: got vld=%b id=%b sum=%h cout=%b rdy=%b exp all zero", vld3, id3, sum3, co3, rdy3);
        end
        req_valid = 2'b00;
        tick();
        rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (vld3) n++;
        end
        n_checks++;
        if (n != 0) begin
            n_fail++;
            $display("FAIL midreset_ghost: got %0d valid cycles exp 0", n);
        end
    endtask

    task automatic test_latency;
        int n = 1;
        do_reset();
        req_valid = 2'b01; a0 = 8'h82; b0 = 8'h05; cin = 2'b00;
        tick();
        req_valid = 2'b00;
        while (!vld4 && n < 10) begin
            tick();
            n++;
        end
        n_checks++;
        if (n != 5) begin
            n_fail++;
            $display("FAIL latency_cycles: got %0d exp 5", n);
        end
        n_checks++;
        if ({vld4, sum4, co4} !== {1'b1, 8'h87, 1'b0}) begin
            n_fail++;
            $display("FAIL latency_rsp: got vld=%b sum=%h cout=%b exp 1 87 0", vld4, sum4, co4);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_latency();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 Parameter ADD_CYCLES, default 1: cycles spent in state ADD per operation; legal range 1..4.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  2  bit i: requester i presents an operand pair.
REQ-005 req_ready  output  2  bit i: requester i's operands are accepted this cycle.
REQ-006 req0_a, req0_b  input  8 each  requester 0 operands.
REQ-007 req1_a, req1_b  input  8 each  requester 1 operands.
REQ-008 req_cin  input  2  bit i: carry-in of requester i.
REQ-009 rsp_valid  output  1  result held and valid.
REQ-010 rsp_ready  input  1  consumer accepts the result.
REQ-011 rsp_id  output  1  index of the requester that owns the result.
REQ-012 rsp_sum  output  8  sum bits [7:0].
REQ-013 rsp_cout  output  1  carry out of bit 7.

Function
REQ-014 The FSM SHALL have three states: IDLE, ADD and RESP.
REQ-015 In IDLE, req_ready SHALL be one-hot toward the granted requester when any req_valid is set, and 2'b00 otherwise.
- Grant is combinational from req_valid and the priority pointer.
REQ-016 Arbitration SHALL be round-robin.
- Single request: granted.
- Both requests: the requester named by pointer prio is granted.
- After each grant, prio <= ~granted index.
REQ-017 On a handshake (req_valid[i] & req_ready[i]):
- latch a, b, cin and id;
- move IDLE -> ADD.
REQ-018 req_ready SHALL be 2'b00 in ADD and RESP.
- Requester operands are not sampled outside IDLE.
REQ-019 ADD SHALL last exactly ADD_CYCLES cycles, then move to RESP.
- On entering RESP: {rsp_cout, rsp_sum} = latched a + b + cin, computed as a 9-bit unsigned sum.
REQ-020 In RESP, rsp_valid = 1 and rsp_sum, rsp_cout and rsp_id SHALL hold stable until rsp_ready = 1.
- Then move RESP -> IDLE; rsp_valid drops on the next cycle.
REQ-021 Handshake-to-rsp_valid latency SHALL be ADD_CYCLES+1 cycles.
- Minimum back-to-back issue interval SHALL be ADD_CYCLES+2 cycles.
REQ-022 Wrap-around: 8'hFF + 8'h01 + 0 SHALL give sum 8'h00, cout 1.
REQ-023 Boundary conditions:
- Requests arriving in ADD/RESP wait; they are not lost or dropped.
- Deasserting req_valid before a grant SHALL be legal.
- rsp_ready asserted outside RESP SHALL be ignored.

Reset
REQ-024 While rst_n = 0, asynchronously:
- state = IDLE, prio = 0;
- rsp_valid = 0, rsp_id = 0, rsp_sum = 8'h00, rsp_cout = 0 (rsp_ovf = 0 when present);
- req_ready = 2'b00;
- the ADD cycle counter = 0.
REQ-025 Reset asserted mid-ADD or mid-RESP SHALL discard the operation; no response is produced after release.
REQ-026 The first rising edge after rst_n rises SHALL be able to grant.

Configuration
REQ-027 Macro ADD_ARBITER_OVF_EN.
- Defined: adds output rsp_ovf (1 bit), two's-complement signed overflow. rsp_ovf = (a[7] == b[7]) & (rsp_sum[7] != a[7]), held and reset like rsp_sum.
- Undefined: port rsp_ovf and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-028 Single requester:
- Stimulus: req0 a=8'h7F, b=8'h00, cin=1, ADD_CYCLES=1.
- Required: req_ready=2'b01 same cycle; rsp_valid 2 cycles later; sum=8'h80, cout=0, id=0; ovf=1 if enabled.
REQ-029 Contention:
- Stimulus: both valid continuously from reset; req0 8'h0E+8'h03, req1 8'hFE+8'h05; rsp_ready=1.
- Required: responses alternate id 0,1,0,...; id0 sum=8'h11 cout=0; id1 sum=8'h03 cout=1.
REQ-030 Backpressure:
- Stimulus: rsp_ready=0 for 5 cycles in RESP, req1 pending.
- Required: outputs stable; req_ready=2'b00 throughout; req1 granted the cycle after rsp_ready=1 is accepted.
REQ-031 Reset mid-operation:
- Stimulus: rst_n pulsed low during ADD with ADD_CYCLES=3.
- Required: all outputs return to reset values immediately; no rsp_valid afterward without a new request.
REQ-032 Latency sweep:
- Stimulus: ADD_CYCLES=4, 8'h82+8'h05.
- Required: rsp_valid exactly 5 cycles after the handshake; sum=8'h87, cout=0.
